// File: rtl/watch_time_gen_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// watch_time_gen_pkg : adjust-select codes and default field geometry
// rev 1.0
// ------------------------------------------------------------------
package watch_time_gen_pkg;

  typedef enum logic [1:0] {
    ADJ_SEC  = 2'd0,
    ADJ_MIN  = 2'd1,
    ADJ_HOUR = 2'd2,
    ADJ_NONE = 2'd3
  } adj_sel_e;

  localparam int DEF_HOUR_W = 5;
  localparam int DEF_MIN_W  = 6;
  localparam int DEF_SEC_W  = 6;
  localparam int DEF_N_HOUR = 24;
  localparam int DEF_N_MIN  = 60;
  localparam int DEF_N_SEC  = 60;

endpackage
`default_nettype wire

// File: rtl/watch_time_gen_if.sv
`default_nettype none
// ------------------------------------------------------------------
// watch_time_gen_if : control strobes and time/display outputs
// rev 1.0
// ------------------------------------------------------------------
interface watch_time_gen_if
  import watch_time_gen_pkg::*;
#(
  parameter int HOUR_W = DEF_HOUR_W,
  parameter int MIN_W  = DEF_MIN_W,
  parameter int SEC_W  = DEF_SEC_W
);

  logic                            en_1hz;
  logic                            run;
  logic                            dir;
  logic                            mode12;
  logic                            set_watch;
  logic [HOUR_W+MIN_W+SEC_W-1:0]   bin_watch;
  logic                            adj_en;
  adj_sel_e                        adj_sel;
  logic                            adj_up;

  logic [HOUR_W-1:0]               hour;
  logic [MIN_W-1:0]                min;
  logic [SEC_W-1:0]                sec;
  logic [HOUR_W-1:0]               hour_disp;
  logic                            ampm;
  logic                            en_min;
  logic                            en_hour;
  logic                            en_day;

  modport master (
    output en_1hz, run, dir, mode12, set_watch, bin_watch, adj_en, adj_sel, adj_up,
    input  hour, min, sec, hour_disp, ampm, en_min, en_hour, en_day
  );

  modport slave (
    input  en_1hz, run, dir, mode12, set_watch, bin_watch, adj_en, adj_sel, adj_up,
    output hour, min, sec, hour_disp, ampm, en_min, en_hour, en_day
  );

endinterface
`default_nettype wire

// File: rtl/watch_time_gen_wrap_counter.sv
`default_nettype none
// ------------------------------------------------------------------
// watch_time_gen_wrap_counter : modulo-N up/down counter with wrap flag
// rev 1.0
// ------------------------------------------------------------------
module watch_time_gen_wrap_counter #(
  parameter int W = 6,
  parameter int N = 60
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] val,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] value,
  output logic         wrap
);

  localparam logic [W-1:0] MAX = W'(N - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= val;
    end else if (inc) begin
      cnt <= (cnt == MAX) ? '0 : cnt + W'(1);
    end else if (dec) begin
      cnt <= (cnt == '0) ? MAX : cnt - W'(1);
    end
  end

  // wrap is qualified by the step direction so it doubles as the carry/borrow out
  assign wrap  = (inc & (cnt == MAX)) | (dec & (cnt == '0));
  assign value = cnt;

endmodule
`default_nettype wire

// File: rtl/watch_time_gen.sv
`default_nettype none
// ------------------------------------------------------------------
// watch_time_gen : hour:min:sec timekeeper with adjust, 12 h display, carry pulses
// rev 1.0
// ------------------------------------------------------------------
module watch_time_gen
  import watch_time_gen_pkg::*;
#(
  parameter int HOUR_W = DEF_HOUR_W,
  parameter int MIN_W  = DEF_MIN_W,
  parameter int SEC_W  = DEF_SEC_W,
  parameter int N_HOUR = DEF_N_HOUR,
  parameter int N_MIN  = DEF_N_MIN,
  parameter int N_SEC  = DEF_N_SEC
) (
  input  logic              clk,
  input  logic              rst,
  watch_time_gen_if.slave   bus
);

  logic              load;
  logic              adj_active;
  logic              tick;
  logic              tick_up;
  logic              tick_dn;
  logic              adj_s, adj_m, adj_h;

  logic [SEC_W-1:0]  sec_ld;
  logic [MIN_W-1:0]  min_ld;
  logic [HOUR_W-1:0] hour_ld;
  logic [SEC_W-1:0]  bin_sec;
  logic [MIN_W-1:0]  bin_min;
  logic [HOUR_W-1:0] bin_hour;

  logic [SEC_W-1:0]  sec_v;
  logic [MIN_W-1:0]  min_v;
  logic [HOUR_W-1:0] hour_v;
  logic [HOUR_W-1:0] hour_disp_v;
  logic              sec_wrap, min_wrap, hour_wrap;
  logic              sec_carry, min_carry, hour_carry;
  logic              en_min_q, en_hour_q, en_day_q;

  assign load       = bus.set_watch;
  assign adj_active = bus.adj_en & ~bus.set_watch;
  assign tick       = bus.run & bus.en_1hz & ~bus.set_watch & ~bus.adj_en;
  assign tick_up    = tick & ~bus.dir;
  assign tick_dn    = tick & bus.dir;

  assign adj_s = adj_active & (bus.adj_sel == ADJ_SEC);
  assign adj_m = adj_active & (bus.adj_sel == ADJ_MIN);
  assign adj_h = adj_active & (bus.adj_sel == ADJ_HOUR);

  assign bin_sec  = bus.bin_watch[SEC_W-1:0];
  assign bin_min  = bus.bin_watch[SEC_W +: MIN_W];
  assign bin_hour = bus.bin_watch[SEC_W+MIN_W +: HOUR_W];

  // out-of-range load fields collapse to zero rather than parking the counter off-modulus
  assign sec_ld  = (32'(bin_sec)  >= 32'(N_SEC))  ? '0 : bin_sec;
  assign min_ld  = (32'(bin_min)  >= 32'(N_MIN))  ? '0 : bin_min;
  assign hour_ld = (32'(bin_hour) >= 32'(N_HOUR)) ? '0 : bin_hour;

  // carries only ripple from a real tick; adjust steps stay within their own field
  assign sec_carry  = tick & sec_wrap;
  assign min_carry  = sec_carry & min_wrap;
  assign hour_carry = min_carry & hour_wrap;

  watch_time_gen_wrap_counter #(.W(SEC_W), .N(N_SEC)) u_sec (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .val   (sec_ld),
    .inc   (tick_up | (adj_s & bus.adj_up)),
    .dec   (tick_dn | (adj_s & ~bus.adj_up)),
    .value (sec_v),
    .wrap  (sec_wrap)
  );

  watch_time_gen_wrap_counter #(.W(MIN_W), .N(N_MIN)) u_min (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .val   (min_ld),
    .inc   ((tick_up & sec_wrap) | (adj_m & bus.adj_up)),
    .dec   ((tick_dn & sec_wrap) | (adj_m & ~bus.adj_up)),
    .value (min_v),
    .wrap  (min_wrap)
  );

  watch_time_gen_wrap_counter #(.W(HOUR_W), .N(N_HOUR)) u_hour (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .val   (hour_ld),
    .inc   ((tick_up & sec_wrap & min_wrap) | (adj_h & bus.adj_up)),
    .dec   ((tick_dn & sec_wrap & min_wrap) | (adj_h & ~bus.adj_up)),
    .value (hour_v),
    .wrap  (hour_wrap)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_min_q  <= 1'b0;
      en_hour_q <= 1'b0;
      en_day_q  <= 1'b0;
    end else begin
      en_min_q  <= sec_carry;
      en_hour_q <= min_carry;
      en_day_q  <= hour_carry;
    end
  end

  generate
    if (N_HOUR == 24) begin : g_disp12
      always_comb begin
        hour_disp_v = hour_v;
        if (bus.mode12) begin
          if (hour_v == '0) begin
            hour_disp_v = HOUR_W'(12);
          end else if (hour_v > HOUR_W'(12)) begin
            hour_disp_v = hour_v - HOUR_W'(12);
          end
        end
      end
    end else begin : g_disp_raw
      assign hour_disp_v = hour_v;
    end
  endgenerate

  assign bus.hour      = hour_v;
  assign bus.min       = min_v;
  assign bus.sec       = sec_v;
  assign bus.hour_disp = hour_disp_v;
  assign bus.ampm      = (32'(hour_v) >= 32'(N_HOUR / 2));
  assign bus.en_min    = en_min_q;
  assign bus.en_hour   = en_hour_q;
  assign bus.en_day    = en_day_q;

endmodule
`default_nettype wire

// File: tb/tb_watch_time_gen.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_watch_time_gen : scoreboard bench for the watch_time_gen timekeeper
// rev 1.0
// ------------------------------------------------------------------
module tb_watch_time_gen;
  import watch_time_gen_pkg::*;

  localparam int DAY = 24 * 3600;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  watch_time_gen_if bus ();

  watch_time_gen dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          checks   = 0;
  int          failures = 0;
  int          t        = 0;   // model time in seconds since midnight
  logic [19:0] q[$];
  logic [19:0] obs_v;
  logic [19:0] exp_v;

  function automatic logic [19:0] pack(int h, int m, int s, bit pm, bit ph, bit pd);
    return {5'(h), 6'(m), 6'(s), pm, ph, pd};
  endfunction

  function automatic logic [19:0] now_v(bit pm, bit ph, bit pd);
    return pack(t / 3600, (t / 60) % 60, t % 60, pm, ph, pd);
  endfunction

  function automatic logic [19:0] observed();
    return {bus.hour, bus.min, bus.sec, bus.en_min, bus.en_hour, bus.en_day};
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
    bus.en_1hz    = 1'b0;
    bus.set_watch = 1'b0;
    bus.adj_en    = 1'b0;
  endtask

  task automatic push_tick(bit d);
    int  old;
    bit  pm, ph, pd;
    @(negedge clk);
    bus.dir    = d;
    bus.en_1hz = 1'b1;
    old = t;
    if (!d) begin
      t  = (t + 1) % DAY;
      pm = (t % 60) == 0;
      ph = (t % 3600) == 0;
      pd = (t == 0);
    end else begin
      pm = (old % 60) == 0;
      ph = (old % 3600) == 0;
      pd = (old == 0);
      t  = (t + DAY - 1) % DAY;
    end
    q.push_back(now_v(pm, ph, pd));
  endtask

  task automatic push_hold_tick();
    @(negedge clk);
    bus.en_1hz = 1'b1;
    q.push_back(now_v(0, 0, 0));
  endtask

  task automatic push_load(int h, int m, int s, bit with_tick);
    @(negedge clk);
    bus.set_watch = 1'b1;
    bus.bin_watch = {5'(h), 6'(m), 6'(s)};
    bus.en_1hz    = with_tick;
    t = (h >= 24 ? 0 : h) * 3600 + (m >= 60 ? 0 : m) * 60 + (s >= 60 ? 0 : s);
    q.push_back(now_v(0, 0, 0));
  endtask

  task automatic push_adj(adj_sel_e sel, bit up, bit with_tick);
    int hh, mm, ss;
    @(negedge clk);
    bus.adj_en  = 1'b1;
    bus.adj_sel = sel;
    bus.adj_up  = up;
    bus.en_1hz  = with_tick;
    hh = t / 3600; mm = (t / 60) % 60; ss = t % 60;
    case (sel)
      ADJ_SEC:  ss = up ? (ss + 1) % 60 : (ss + 59) % 60;
      ADJ_MIN:  mm = up ? (mm + 1) % 60 : (mm + 59) % 60;
      ADJ_HOUR: hh = up ? (hh + 1) % 24 : (hh + 23) % 24;
      default:  ;
    endcase
    t = hh * 3600 + mm * 60 + ss;
    q.push_back(now_v(0, 0, 0));
  endtask

  task automatic test_reset();
    rst           = 1'b0;
    bus.en_1hz    = 1'b0;
    bus.run       = 1'b1;
    bus.dir       = 1'b0;
    bus.mode12    = 1'b0;
    bus.set_watch = 1'b0;
    bus.bin_watch = '0;
    bus.adj_en    = 1'b0;
    bus.adj_sel   = ADJ_NONE;
    bus.adj_up    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (observed() !== 20'h0) begin
      failures++;
      $display("FAIL reset_fields got=%h exp=%h", observed(), 20'h0);
    end
    checks++;
    if ({bus.hour_disp, bus.ampm} !== {5'd0, 1'b0}) begin
      failures++;
      $display("FAIL reset_disp24 got=%0d/%b exp=0/0", bus.hour_disp, bus.ampm);
    end
    bus.mode12 = 1'b1;
    #1;
    checks++;
    if (bus.hour_disp !== 5'd12) begin
      failures++;
      $display("FAIL reset_disp12 got=%0d exp=12", bus.hour_disp);
    end
    bus.mode12 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    t   = 0;
  endtask

  task automatic test_count_up();
    for (int i = 1; i <= 61; i++) begin
      push_tick(0);
      cycle();
      obs_v = observed();
      exp_v = q.pop_front();
      checks++;
      if (obs_v !== exp_v) begin
        failures++;
        $display("FAIL count_up tick=%0d got=%h exp=%h", i, obs_v, exp_v);
      end
    end
    checks++;
    if ({bus.hour, bus.min, bus.sec} !== {5'd0, 6'd1, 6'd1}) begin
      failures++;
      $display("FAIL count_up_final got=%0d:%0d:%0d exp=0:1:1", bus.hour, bus.min, bus.sec);
    end
  endtask

  task automatic test_day_wrap();
    push_load(23, 59, 59, 0);
    cycle();
    obs_v = observed(); exp_v = q.pop_front(); checks++;
    if (obs_v !== exp_v) begin
      failures++; $display("FAIL day_load got=%h exp=%h", obs_v, exp_v);
    end
    push_tick(0);
    cycle();
    obs_v = observed(); exp_v = q.pop_front(); checks++;
    if (obs_v !== exp_v) begin
      failures++; $display("FAIL day_wrap got=%h exp=%h", obs_v, exp_v);
    end
    @(negedge clk);
    q.push_back(now_v(0, 0, 0));
    cycle();
    obs_v = observed(); exp_v = q.pop_front(); checks++;
    if (obs_v !== exp_v) begin
      failures++; $display("FAIL day_pulse_width got=%h exp=%h", obs_v, exp_v);
    end
  endtask

  task automatic test_count_down();
    push_load(0, 0, 0, 0);
    cycle();
    obs_v = observed(); exp_v = q.pop_front(); checks++;
    if (obs_v !== exp_v) begin
      failures++; $display("FAIL down_load got=%h exp=%h", obs_v, exp_v);
    end
    for (int i = 0; i < 3; i++) begin
      push_tick(1);
      cycle();
      obs_v = observed(); exp_v = q.pop_front(); checks++;
      if (obs_v !== exp_v) begin
        failures++; $display("FAIL count_down step=%0d got=%h exp=%h", i, obs_v, exp_v);
      end
    end
    bus.dir = 1'b0;
  endtask

  task automatic test_adjust();
    push_load(10, 59, 30, 0);
    cycle();
    obs_v = observed(); exp_v = q.pop_front(); checks++;
    if (obs_v !== exp_v) begin
      failures++; $display("FAIL adj_load got=%h exp=%h", obs_v, exp_v);
    end
    push_adj(ADJ_MIN, 1, 0);  cycle();
    obs_v = observed(); exp_v = q.pop_front(); checks++;
    if (obs_v !== exp_v) begin
      failures++; $display("FAIL adj_min_up got=%h exp=%h", obs_v, exp_v);
    end
    push_adj(ADJ_MIN, 0, 0);  cycle();
    obs_v = observed(); exp_v = q.pop_front(); checks++;
    if (obs_v !== exp_v) begin
      failures++; $display("FAIL adj_min_down got=%h exp=%h", obs_v, exp_v);
    end
    push_adj(ADJ_NONE, 1, 0); cycle();
    obs_v = observed(); exp_v = q.pop_front(); checks++;
    if (obs_v !== exp_v) begin
      failures++; $display("FAIL adj_none got=%h exp=%h", obs_v, exp_v);
    end
    push_adj(ADJ_SEC, 1, 1);  cycle();
    obs_v = observed(); exp_v = q.pop_front(); checks++;
    if (obs_v !== exp_v) begin
      failures++; $display("FAIL adj_sec_with_tick got=%h exp=%h", obs_v, exp_v);
    end
    push_load(23, 0, 0, 0);   cycle();
    void'(q.pop_front());
    push_adj(ADJ_HOUR, 1, 0); cycle();
    obs_v = observed(); exp_v = q.pop_front(); checks++;
    if (obs_v !== exp_v) begin
      failures++; $display("FAIL adj_hour_up got=%h exp=%h", obs_v, exp_v);
    end
    push_adj(ADJ_HOUR, 0, 0); cycle();
    obs_v = observed(); exp_v = q.pop_front(); checks++;
    if (obs_v !== exp_v) begin
      failures++; $display("FAIL adj_hour_down got=%h exp=%h", obs_v, exp_v);
    end
  endtask

  task automatic test_display();
    int hours[6] = '{0, 1, 11, 12, 13, 23};
    int hd;
    bus.mode12 = 1'b1;
    foreach (hours[i]) begin
      push_load(hours[i], 30, 0, 0);
      cycle();
      obs_v = observed(); exp_v = q.pop_front(); checks++;
      if (obs_v !== exp_v) begin
        failures++; $display("FAIL disp_load h=%0d got=%h exp=%h", hours[i], obs_v, exp_v);
      end
      hd = (hours[i] == 0) ? 12 : (hours[i] > 12 ? hours[i] - 12 : hours[i]);
      checks++;
      if ({bus.hour_disp, bus.ampm} !== {5'(hd), (hours[i] >= 12)}) begin
        failures++;
        $display("FAIL disp12 h=%0d got=%0d/%b exp=%0d/%b", hours[i], bus.hour_disp, bus.ampm,
                 hd, (hours[i] >= 12));
      end
    end
    push_load(13, 0, 0, 0);
    cycle();
    void'(q.pop_front());
    bus.mode12 = 1'b0;
    #1;
    checks++;
    if ({bus.hour_disp, bus.ampm} !== {5'd13, 1'b1}) begin
      failures++; $display("FAIL disp24 got=%0d/%b exp=13/1", bus.hour_disp, bus.ampm);
    end
  endtask

  task automatic test_pause();
    push_load(4, 59, 59, 0);
    cycle();
    void'(q.pop_front());
    bus.run = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push_hold_tick();
      cycle();
      obs_v = observed(); exp_v = q.pop_front(); checks++;
      if (obs_v !== exp_v) begin
        failures++; $display("FAIL pause_hold i=%0d got=%h exp=%h", i, obs_v, exp_v);
      end
    end
    bus.run = 1'b1;
  endtask

  task automatic test_load_range();
    push_load(5, 10, 60, 0);  cycle();
    obs_v = observed(); exp_v = q.pop_front(); checks++;
    if (obs_v !== exp_v) begin
      failures++; $display("FAIL load_sec60 got=%h exp=%h", obs_v, exp_v);
    end
    push_load(24, 63, 59, 0); cycle();
    obs_v = observed(); exp_v = q.pop_front(); checks++;
    if (obs_v !== exp_v) begin
      failures++; $display("FAIL load_hour_min_range got=%h exp=%h", obs_v, exp_v);
    end
    push_load(7, 8, 9, 1);    cycle();
    obs_v = observed(); exp_v = q.pop_front(); checks++;
    if (obs_v !== exp_v) begin
      failures++; $display("FAIL load_with_tick got=%h exp=%h", obs_v, exp_v);
    end
  endtask

  task automatic test_async_reset();
    push_tick(0);
    cycle();
    obs_v = observed(); exp_v = q.pop_front(); checks++;
    if (obs_v !== exp_v) begin
      failures++; $display("FAIL pre_reset got=%h exp=%h", obs_v, exp_v);
    end
    @(negedge clk);
    #2;
    bus.set_watch = 1'b1;
    bus.bin_watch = {5'd9, 6'd9, 6'd9};
    rst = 1'b0;
    #1;
    checks++;
    if (observed() !== 20'h0) begin
      failures++; $display("FAIL async_reset got=%h exp=%h", observed(), 20'h0);
    end
    @(posedge clk);
    #1;
    checks++;
    if (observed() !== 20'h0) begin
      failures++; $display("FAIL reset_hold got=%h exp=%h", observed(), 20'h0);
    end
    bus.set_watch = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    t   = 0;
    push_tick(0);
    cycle();
    obs_v = observed(); exp_v = q.pop_front(); checks++;
    if (obs_v !== exp_v) begin
      failures++; $display("FAIL post_reset_tick got=%h exp=%h", obs_v, exp_v);
    end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_day_wrap();
    test_count_down();
    test_adjust();
    test_display();
    test_pause();
    test_load_range();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
